// File: rtl/ip_tx_arbiter.sv
// Round-robin, frame-granular arbiter feeding one IP TX header + payload port
// from S_COUNT requesters, with a payload-stall watchdog that aborts stuck frames.
module ip_tx_arbiter #(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 1024,
    localparam int GW        = (S_COUNT > 1) ? $clog2(S_COUNT) : 1,
    localparam int WD_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [S_COUNT-1:0]            s_ip_hdr_valid,
    output logic [S_COUNT-1:0]            s_ip_hdr_ready,
    input  logic [S_COUNT*6-1:0]          s_ip_dscp,
    input  logic [S_COUNT*2-1:0]          s_ip_ecn,
    input  logic [S_COUNT*16-1:0]         s_ip_length,
    input  logic [S_COUNT*8-1:0]          s_ip_ttl,
    input  logic [S_COUNT*8-1:0]          s_ip_protocol,
    input  logic [S_COUNT*32-1:0]         s_ip_source_ip,
    input  logic [S_COUNT*32-1:0]         s_ip_dest_ip,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_ip_payload_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0] s_ip_payload_axis_tkeep,
    input  logic [S_COUNT-1:0]            s_ip_payload_axis_tvalid,
    input  logic [S_COUNT-1:0]            s_ip_payload_axis_tlast,
    input  logic [S_COUNT-1:0]            s_ip_payload_axis_tuser,
    output logic [S_COUNT-1:0]            s_ip_payload_axis_tready,
    output logic                          m_ip_hdr_valid,
    input  logic                          m_ip_hdr_ready,
    output logic [5:0]                    m_ip_dscp,
    output logic [1:0]                    m_ip_ecn,
    output logic [15:0]                   m_ip_length,
    output logic [7:0]                    m_ip_ttl,
    output logic [7:0]                    m_ip_protocol,
    output logic [31:0]                   m_ip_source_ip,
    output logic [31:0]                   m_ip_dest_ip,
    output logic [DATA_WIDTH-1:0]         m_ip_payload_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_ip_payload_axis_tkeep,
    output logic                          m_ip_payload_axis_tvalid,
    output logic                          m_ip_payload_axis_tlast,
    output logic                          m_ip_payload_axis_tuser,
    input  logic                          m_ip_payload_axis_tready,
    output logic [GW-1:0]                 grant,
    output logic                          busy,
    output logic                          error_timeout
);

    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, ABORT, DRAIN} state_t;

    state_t          state, state_n;
    logic [GW-1:0]   grant_n, rr_ptr, rr_n, pick, grant_nxt;
    logic [WD_W-1:0] wd, wd_n;
    logic            abort_ack;
    logic            own_valid, own_last;

    function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int off);
        int j;
        j = int'(base) + off;
        if (j >= S_COUNT) j = j - S_COUNT;
        return GW'(j);
    endfunction

    // Scan downward so the last hit is the one closest to rr_ptr.
    always_comb begin
        pick = rr_ptr;
        for (int i = S_COUNT - 1; i >= 0; i--) begin
            if (s_ip_hdr_valid[rr_idx(rr_ptr, i)]) pick = rr_idx(rr_ptr, i);
        end
    end

    assign grant_nxt = (grant == GW'(S_COUNT - 1)) ? '0 : grant + 1'b1;
    assign own_valid = s_ip_payload_axis_tvalid[grant];
    assign own_last  = s_ip_payload_axis_tlast[grant];
    assign busy      = (state != IDLE);

    always_comb begin
        state_n                  = state;
        grant_n                  = grant;
        rr_n                     = rr_ptr;
        wd_n                     = wd;
        abort_ack                = 1'b0;
        s_ip_hdr_ready           = '0;
        s_ip_payload_axis_tready = '0;
        m_ip_hdr_valid           = 1'b0;
        m_ip_dscp                = '0;
        m_ip_ecn                 = '0;
        m_ip_length              = '0;
        m_ip_ttl                 = '0;
        m_ip_protocol            = '0;
        m_ip_source_ip           = '0;
        m_ip_dest_ip             = '0;
        m_ip_payload_axis_tdata  = '0;
        m_ip_payload_axis_tkeep  = '0;
        m_ip_payload_axis_tvalid = 1'b0;
        m_ip_payload_axis_tlast  = 1'b0;
        m_ip_payload_axis_tuser  = 1'b0;
        case (state)
            IDLE: begin
                if (|s_ip_hdr_valid) begin
                    grant_n = pick;
                    state_n = HDR;
                end
            end
            HDR: begin
                m_ip_hdr_valid        = 1'b1;
                m_ip_dscp             = s_ip_dscp[grant*6 +: 6];
                m_ip_ecn              = s_ip_ecn[grant*2 +: 2];
                m_ip_length           = s_ip_length[grant*16 +: 16];
                m_ip_ttl              = s_ip_ttl[grant*8 +: 8];
                m_ip_protocol         = s_ip_protocol[grant*8 +: 8];
                m_ip_source_ip        = s_ip_source_ip[grant*32 +: 32];
                m_ip_dest_ip          = s_ip_dest_ip[grant*32 +: 32];
                s_ip_hdr_ready[grant] = m_ip_hdr_ready;
                if (m_ip_hdr_ready) begin
                    state_n = PAYLOAD;
                    wd_n    = '0;
                end
            end
            PAYLOAD: begin
                m_ip_payload_axis_tdata         = s_ip_payload_axis_tdata[grant*DATA_WIDTH +: DATA_WIDTH];
                m_ip_payload_axis_tkeep         = s_ip_payload_axis_tkeep[grant*KEEP_WIDTH +: KEEP_WIDTH];
                m_ip_payload_axis_tvalid        = own_valid;
                m_ip_payload_axis_tlast         = own_last;
                m_ip_payload_axis_tuser         = s_ip_payload_axis_tuser[grant];
                s_ip_payload_axis_tready[grant] = m_ip_payload_axis_tready;
                wd_n = own_valid ? '0 : wd + 1'b1;
                if (own_valid && own_last && m_ip_payload_axis_tready) begin
                    state_n = IDLE;
                    rr_n    = grant_nxt;
                end else if (TIMEOUT != 0 && !own_valid && wd == WD_W'(TIMEOUT - 1)) begin
                    state_n = ABORT;
                end
            end
            ABORT: begin
                // Synthetic terminating beat flagged bad via tuser.
                m_ip_payload_axis_tvalid = 1'b1;
                m_ip_payload_axis_tlast  = 1'b1;
                m_ip_payload_axis_tuser  = 1'b1;
                m_ip_payload_axis_tkeep  = {{(KEEP_WIDTH-1){1'b0}}, 1'b1};
                if (m_ip_payload_axis_tready) begin
                    abort_ack = 1'b1;
                    state_n   = DRAIN;
                end
            end
            DRAIN: begin
                s_ip_payload_axis_tready[grant] = 1'b1;
                if (own_valid && own_last) begin
                    state_n = IDLE;
                    rr_n    = grant_nxt;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            grant         <= '0;
            rr_ptr        <= '0;
            wd            <= '0;
            error_timeout <= 1'b0;
        end else begin
            state         <= state_n;
            grant         <= grant_n;
            rr_ptr        <= rr_n;
            wd            <= wd_n;
            error_timeout <= abort_ack;
        end
    end

endmodule

// File: doc/ip_tx_arbiter.md
Name: ip_tx_arbiter

Overview:
- Round-robin, frame-granular arbiter that shares the single IP TX input of udp_complete_64 between S_COUNT local requesters.
- Each requester drives one IP header plus a 64-bit AXI-Stream payload.
- Once a requester's header is granted, it owns the IP TX path until its payload tlast is accepted.
- A stall watchdog force-terminates a frame whose owner stops supplying payload, so the shared path is not held indefinitely.

Parameters:
S_COUNT, 4, number of requesters (2..8)
DATA_WIDTH, 64, payload width
KEEP_WIDTH, 8, DATA_WIDTH/8
TIMEOUT, 1024, idle payload cycles before abort; 0 disables the watchdog

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_ip_hdr_valid  in  S_COUNT  per-requester header valid
s_ip_hdr_ready  out  S_COUNT  per-requester header ready
s_ip_dscp/s_ip_ecn/s_ip_length/s_ip_ttl/s_ip_protocol/s_ip_source_ip/s_ip_dest_ip  in  S_COUNT*{6,2,16,8,8,32,32}  packed header fields, requester i in slice i
s_ip_payload_axis_tdata/tkeep  in  S_COUNT*DATA_WIDTH / S_COUNT*KEEP_WIDTH  packed payload
s_ip_payload_axis_tvalid/tlast/tuser  in  S_COUNT  payload controls
s_ip_payload_axis_tready  out  S_COUNT  payload ready
m_ip_hdr_valid  out  1  to the DUT s_ip_hdr_valid
m_ip_hdr_ready  in  1  from the DUT
m_ip_dscp,m_ip_ecn,m_ip_length,m_ip_ttl,m_ip_protocol,m_ip_source_ip,m_ip_dest_ip  out  6,2,16,8,8,32,32  muxed header
m_ip_payload_axis_tdata/tkeep/tvalid/tlast/tuser  out  64/8/1/1/1  muxed payload
m_ip_payload_axis_tready  in  1  downstream ready
grant  out  $clog2(S_COUNT)  current owner index
busy  out  1  high in any state other than IDLE
error_timeout  out  1  one-cycle pulse per abort

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE, rr_ptr=0, grant=0, watchdog=0.
  - All valid/ready/last/user outputs 0; busy=0; error_timeout=0.
  - m_ip_* data buses 0.
- IDLE:
  - When any s_ip_hdr_valid is high, register grant = the first requester at or after rr_ptr (modulo S_COUNT), then go to HDR.
  - No s_*_ready is asserted in IDLE.
- HDR:
  - m_ip_hdr_valid=1; header fields are a combinational mux of slice[grant].
  - s_ip_hdr_ready[grant]=m_ip_hdr_ready; all other ready bits are 0.
  - On handshake, go to PAYLOAD and clear watchdog.
  - Latency: first m_ip_hdr_valid appears 1 cycle after s_ip_hdr_valid rises.
- PAYLOAD:
  - Pure combinational pass-through: m_tdata/tkeep/tvalid/tlast/tuser = slice[grant]; s_tready[grant]=m_tready; all others 0.
  - Zero added latency and full throughput.
  - watchdog increments on every cycle where s_tvalid[grant]=0 and resets on every cycle where it is 1.
  - A beat with tlast accepted -> IDLE, rr_ptr=(grant+1) mod S_COUNT.
  - watchdog==TIMEOUT-1 while still idle (TIMEOUT != 0) -> ABORT.
- ABORT:
  - Drive m_tvalid=1, tlast=1, tuser=1, tkeep=8'h01, tdata=0.
  - Requester readies are 0.
  - On m_tready, pulse error_timeout and go to DRAIN.
- DRAIN:
  - s_tready[grant]=1; m_tvalid=0.
  - Discard the owner's beats until one with tlast is accepted.
  - Then -> IDLE, rr_ptr=grant+1.
- Requester deasserting s_ip_hdr_valid while in HDR before the handshake: arbiter stays in HDR (AXI rule violation; no recovery required).
- Simultaneous requests: the rotating pointer guarantees each requester waits at most S_COUNT-1 frames.
- New requests arriving in PAYLOAD do not preempt the current owner.
- Header and payload of the same requester may be valid in the same cycle; payload is held off (tready=0) until the header handshake completes.
- A single-beat frame (tlast on first beat) returns to IDLE the same cycle the beat is accepted.
- A new grant can be issued on the next cycle (IDLE one cycle minimum between frames).
- rst_n asserted mid-frame: all outputs drop immediately; the downstream frame is left truncated (system reset).

Test Plan:
- Req1 only, 3-beat frame (tkeep FF,FF,0F), m_tready=1 -> m_ip_hdr_valid 1 cycle after request; m_ip_dest_ip=C0A80166; 3 beats out unchanged; tlast on beat 3; grant=1; busy falls after tlast.
- Req0,1,2,3 all valid simultaneously, 2-beat frames -> output frame order 0,1,2,3; then re-request 0 and 2 -> order 0,2 (rr_ptr=0 after grant 3).
- Backpressure: m_ip_payload_axis_tready toggles 1,0,1,0 -> every s_tready[grant] mirrors it; no beat is lost or duplicated; non-owner tready stays 0 throughout.
- TIMEOUT=16: owner sends 1 beat, then tvalid=0 for 20 cycles -> after 16 idle cycles an abort beat appears (tlast=1, tuser=1, tkeep=01); error_timeout pulses once; owner's later 2 beats plus tlast are consumed with m_tvalid=0; next requester is then granted.
- Reset mid-PAYLOAD (rst_n low for 2 cycles) -> all valid/ready outputs 0 asynchronously; after release, state=IDLE and the first pending request is granted from index 0.
- Single-beat frames back-to-back from req2 -> each frame's header and data pass through; one IDLE cycle between frames; grant stays 2 when it is the only requester.
